// File: rtl/mul_pkg.sv
// Shared types and helpers for the digit-serial multiplier sequencer.
// Optional zero-operand shortcut in mul_seq_ctrl is enabled by MUL_SEQ_ZERO_SKIP_EN.
package mul_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  // Width of the digit-pair index counting 0..n*n-1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/mul4x4_core.sv
// Combinational 4x4 -> 8 unsigned array multiplier: sum of AND-gated, shifted rows.
module mul4x4_core
  import mul_pkg::*;
(
  input  logic [DIGIT_W-1:0]   x,
  input  logic [DIGIT_W-1:0]   y,
  output logic [2*DIGIT_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int k = 0; k < DIGIT_W; k++) begin
      if (y[k]) p = p + ((2 * DIGIT_W)'(x) << k);
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequenced WIDTH x WIDTH unsigned multiplier time-sharing one 4x4 core, one digit pair per cycle.
// Define MUL_SEQ_ZERO_SKIP_EN to bypass CALC when either operand is zero at acceptance.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int unsigned N = WIDTH / DIGIT_W;
  localparam int unsigned IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N * N - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc_q;

  logic [IDX_W-1:0]     dig_i, dig_j;
  logic [DIGIT_W-1:0]   digit_a, digit_b;
  logic [2*DIGIT_W-1:0] prod;
  logic [2*WIDTH-1:0]   term, acc_sum;

  always_comb begin
    dig_i   = idx_q % IDX_W'(N);
    dig_j   = idx_q / IDX_W'(N);
    digit_a = a_q[DIGIT_W*dig_i +: DIGIT_W];
    digit_b = b_q[DIGIT_W*dig_j +: DIGIT_W];
    term    = (2 * WIDTH)'(prod) << (DIGIT_W * (dig_i + dig_j));
    acc_sum = acc_q + term;
  end

  mul4x4_core u_core (
    .x(digit_a),
    .y(digit_b),
    .p(prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            acc_q    <= '0;
            idx_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef MUL_SEQ_ZERO_SKIP_EN
            state_q  <= (a == '0 || b == '0) ? StDone : StCalc;
`else
            state_q  <= StCalc;
`endif
          end
        end
        StCalc: begin
          acc_q <= acc_sum;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            result    <= acc_sum;
          end
        end
        StDone: begin
          // Arriving without out_valid means the zero shortcut: publish acc (0) this cycle.
          if (!out_valid) begin
            out_valid <= 1'b1;
            result    <= acc_q;
          end else if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed vector table, reset/backpressure
// sequences, and randomized ops scored against plain a*b for WIDTH=8 and WIDTH=12.
module tb_mul_seq_ctrl;

`ifdef MUL_SEQ_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] result;

  logic        in_valid12, in_ready12, out_valid12, out_ready12, busy12;
  logic [11:0] a12, b12;
  logic [23:0] result12;

  int n_tests = 0;
  int n_fail  = 0;
  int popped  = 0;
  logic [15:0] sb_q[$];

  mul_seq_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  mul_seq_ctrl #(.WIDTH(12)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid12), .in_ready(in_ready12), .a(a12), .b(b12),
    .out_valid(out_valid12), .out_ready(out_ready12), .result(result12), .busy(busy12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y, input int full);
    return (SKIP && (x == 8'd0 || y == 8'd0)) ? 1 : full;
  endfunction

  // One 8-bit op: accept, wait for out_valid, hold with out_ready=0, then release.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input int hold,
                     output logic [15:0] res, output int lat);
    int guard;
    logic [15:0] held;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", 64'(in_ready), 64'(1));
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a = ta;
    b = tb_v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      check("in_ready_calc", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      lat++;
    end
    check("in_ready_done", 64'(in_ready), 64'(0));
    check("busy_done", 64'(busy), 64'(1));
    res  = result;
    held = result;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_result", 64'(result), 64'(held));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_one_cycle", 64'(out_valid), 64'(0));
    check("idle_after_ready", 64'(in_ready), 64'(1));
    check("result_kept", 64'(result), 64'(held));
  endtask

  task automatic reset_mid_calc();
    in_valid = 1'b1;
    a = 8'h09;
    b = 8'h09;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    check("rst_op_lost", 64'(out_valid), 64'(0));
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] res;
    int          lat;

    vecs[0] = '{a: 8'hFF, b: 8'hFF, exp: 16'hFE01, hold: 0};
    vecs[1] = '{a: 8'h0F, b: 8'h10, exp: 16'h00F0, hold: 0};
    vecs[2] = '{a: 8'hA5, b: 8'h3C, exp: 16'h26AC, hold: 1};
    vecs[3] = '{a: 8'h12, b: 8'h34, exp: 16'h03A8, hold: 5};
    vecs[4] = '{a: 8'h03, b: 8'h05, exp: 16'h000F, hold: 0};
    vecs[5] = '{a: 8'h00, b: 8'h7E, exp: 16'h0000, hold: 2};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    in_valid12 = 1'b0; a12 = '0; b12 = '0; out_ready12 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset12_in_ready", 64'(in_ready12), 64'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      if (k == 4) reset_mid_calc();
      op8(vecs[k].a, vecs[k].b, vecs[k].hold, res, lat);
      check($sformatf("vec%0d_result", k), 64'(res), 64'(vecs[k].exp));
      check($sformatf("vec%0d_latency", k), 64'(lat), 64'(exp_lat(vecs[k].a, vecs[k].b, 4)));
    end

    // Random back-to-back ops with random backpressure, scored in order.
    fork
      begin : drv
        for (int k = 0; k < 500; k++) begin
          logic [7:0] ra, rb;
          bit took;
          int g;
          ra = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
          rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
          in_valid = 1'b1;
          a = ra;
          b = rb;
          took = 1'b0;
          g = 0;
          while (!took && g < 100) begin
            took = in_ready;
            @(posedge clk); #1;
            g++;
          end
          if (!took) begin
            n_tests++;
            n_fail++;
            $display("FAIL rand_accept: op %0d not accepted, expected accept within 100 cycles", k);
          end else begin
            sb_q.push_back(16'(ra) * 16'(rb));
          end
          in_valid = 1'b0;
          a = 8'($urandom);
          b = 8'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      begin : mon
        int cyc;
        cyc = 0;
        while (popped < 500 && cyc < 30000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL rand_spurious: got result %0h, expected no pending op", result);
            end else begin
              check("rand_result", 64'(result), 64'(sb_q.pop_front()));
            end
            popped++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    check("rand_count", 64'(popped), 64'(500));
    check("rand_queue_empty", 64'(sb_q.size()), 64'(0));

    // WIDTH=12: nine CALC cycles per op.
    for (int k = 0; k < 100; k++) begin
      logic [11:0] ra, rb;
      int g, l12, hold;
      ra = 12'($urandom_range(1, 4095));
      rb = 12'($urandom_range(1, 4095));
      g = 0;
      while (!in_ready12 && g < 50) begin
        @(posedge clk); #1;
        g++;
      end
      in_valid12 = 1'b1;
      a12 = ra;
      b12 = rb;
      @(posedge clk); #1;
      in_valid12 = 1'b0;
      a12 = 12'($urandom);
      b12 = 12'($urandom);
      l12 = 0;
      while (!out_valid12 && l12 < 50) begin
        @(posedge clk); #1;
        l12++;
      end
      check("w12_latency", 64'(l12), 64'(9));
      check("w12_result", 64'(result12), 64'(24'(ra) * 24'(rb)));
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
      end
      out_ready12 = 1'b1;
      @(posedge clk); #1;
      out_ready12 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
